arc4_crack_ctrl: RTL and testbench

Key-search controller that sequences one `arc4` decryption core over a range of candidate keys and judges each decryption. It owns the `pt_mem` port, handing it to `arc4` while a decryption runs and taking it back to scan the length-prefixed plaintext for printable ASCII. It sits between the board-level top and the `arc4`/`pt_mem` pair. Two instances with `KEY_STEP=2` and interleaved `key_base` form a dual-core cracker.

---
 rtl/arc4_crack_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_arc4_crack_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_crack_ctrl.sv
// Key-search controller: sequences one arc4 core over candidate keys,
// owns pt_mem and scans the decrypted text. Option: CRACK_EARLY_EXIT_EN.
module arc4_crack_ctrl #(
    parameter int KEY_W    = 24,
    parameter int KEY_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key_base,
    output logic             key_valid,
    output logic [KEY_W-1:0] key,
    output logic             a4_en,
    input  logic             a4_rdy,
    output logic [KEY_W-1:0] a4_key,
    input  logic [7:0]       a4_pt_addr,
    input  logic [7:0]       a4_pt_wrdata,
    input  logic             a4_pt_wren,
    output logic [7:0]       pt_addr,
    output logic [7:0]       pt_wrdata,
    output logic             pt_wren,
    input  logic [7:0]       pt_rddata
);

`ifdef CRACK_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_LEN,
        S_SCAN,
        S_NEXT
    } state_t;

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic             key_valid_q, key_valid_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] cur_key_q, cur_key_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic             bad_q, bad_d;
    logic             len_ph_q, len_ph_d;

    logic [KEY_W:0]   key_sum;
    logic             byte_ok;
    logic             hit_bad;
    logic             found;
    logic             a4_en_c;
    logic [7:0]       ctl_addr;
    logic             pass;

    assign key_sum = {1'b0, cur_key_q} + (KEY_W+1)'(KEY_STEP);
    assign byte_ok = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);

    // Next-state and datapath updates for the search sequence
    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        key_d       = key_q;
        cur_key_d   = cur_key_q;
        len_d       = len_q;
        idx_d       = idx_q;
        bad_d       = bad_q;
        len_ph_d    = len_ph_q;
        a4_en_c     = 1'b0;
        ctl_addr    = 8'd0;
        hit_bad     = 1'b0;
        found       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en && rdy_q) begin
                    cur_key_d   = key_base;
                    key_valid_d = 1'b0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (a4_rdy) begin
                    a4_en_c = 1'b1;
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!a4_rdy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (a4_rdy) begin
                    len_ph_d = 1'b0;
                    state_d  = S_LEN;
                end
            end
            S_LEN: begin
                if (!len_ph_q) begin
                    len_ph_d = 1'b1;
                end else begin
                    len_d = pt_rddata;
                    idx_d = 8'd0;
                    bad_d = 1'b0;
                    if (pt_rddata == 8'd0) begin
                        found = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (idx_q < len_q) begin
                    ctl_addr = idx_q + 8'd1;
                end
                hit_bad = (idx_q != 8'd0) && !byte_ok;
                bad_d   = bad_q | hit_bad;
                idx_d   = idx_q + 8'd1;
                if ((EARLY && hit_bad) || (idx_q == len_q)) begin
                    if (bad_d) begin
                        state_d = S_NEXT;
                    end else begin
                        found = 1'b1;
                    end
                end
            end
            S_NEXT: begin
                if (key_sum[KEY_W]) begin
                    key_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cur_key_d = key_sum[KEY_W-1:0];
                    state_d   = S_LAUNCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (found) begin
            key_d       = cur_key_q;
            key_valid_d = 1'b1;
            state_d     = S_IDLE;
        end

        rdy_d = (state_d == S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_q       <= '0;
            cur_key_q   <= '0;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            bad_q       <= 1'b0;
            len_ph_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            key_valid_q <= key_valid_d;
            key_q       <= key_d;
            cur_key_q   <= cur_key_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            bad_q       <= bad_d;
            len_ph_q    <= len_ph_d;
        end
    end

    // pt_mem port belongs to arc4 only while a decryption is in flight
    always_comb begin
        pass = (state_q == S_LAUNCH) ||
               (state_q == S_WAIT_BUSY) ||
               (state_q == S_WAIT_DONE);
        if (pass) begin
            pt_addr   = a4_pt_addr;
            pt_wrdata = a4_pt_wrdata;
            pt_wren   = a4_pt_wren;
        end else begin
            pt_addr   = ctl_addr;
            pt_wrdata = 8'd0;
            pt_wren   = 1'b0;
        end
    end

    assign rdy       = rdy_q;
    assign key_valid = key_valid_q;
    assign key       = key_q;
    assign a4_key    = cur_key_q;
    assign a4_en     = a4_en_c;

endmodule

// File: tb/tb_arc4_crack_ctrl.sv
// Randomized bench for arc4_crack_ctrl with an arc4 and pt_mem model.
// Expectations follow CRACK_EARLY_EXIT_EN when defined.
module tb_arc4_crack_ctrl;

    localparam int KW    = 24;
    localparam int TSTEP = 1;
    localparam int KMAX  = (1 << KW) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic          rdy;
    logic [KW-1:0] key_base;
    logic          key_valid;
    logic [KW-1:0] key;
    logic          a4_en;
    logic          a4_rdy;
    logic [KW-1:0] a4_key;
    logic [7:0]    a4_pt_addr;
    logic [7:0]    a4_pt_wrdata;
    logic          a4_pt_wren;
    logic [7:0]    pt_addr;
    logic [7:0]    pt_wrdata;
    logic          pt_wren;
    logic [7:0]    pt_rddata;

    arc4_crack_ctrl #(.KEY_W(KW), .KEY_STEP(TSTEP)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy),
        .key_base(key_base), .key_valid(key_valid), .key(key),
        .a4_en(a4_en), .a4_rdy(a4_rdy), .a4_key(a4_key),
        .a4_pt_addr(a4_pt_addr), .a4_pt_wrdata(a4_pt_wrdata),
        .a4_pt_wren(a4_pt_wren),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren),
        .pt_rddata(pt_rddata)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    int good_key, len_cfg, bpos_cfg, bbyte_cfg;
    int last_len, last_bad, done_cyc;
    bit have_prev;
    int launched[$];
    bit prev_en = 0;

    logic [7:0] mem [256];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rej_lat(input int n, input int bp);
`ifdef CRACK_EARLY_EXIT_EN
        return bp + 5;
`else
        return n + 5;
`endif
    endfunction

    function automatic int hit_lat(input int n);
        return (n == 0) ? 3 : n + 4;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // pt_mem: address registered, data one cycle later
    always @(posedge clk) begin
        if (pt_wren) mem[pt_addr] <= pt_wrdata;
        pt_rddata <= mem[pt_addr];
    end

    // a4_en must be a single-cycle pulse
    initial begin
        forever begin
            @(negedge clk);
            if (a4_en) chk("a4en_1cyc", {31'd0, prev_en}, 0);
            prev_en = a4_en;
        end
    end

    // arc4 model: fills pt_mem with a length-prefixed message per key
    initial begin
        int k, n, bp;
        logic [7:0] b;
        a4_rdy = 1;
        a4_pt_addr = 0;
        a4_pt_wrdata = 0;
        a4_pt_wren = 0;
        forever begin
            @(negedge clk);
            if (a4_en === 1'b1 && rst === 1'b0) begin
                k = int'(a4_key);
                if (have_prev)
                    chk("rej_lat", cyc - done_cyc, rej_lat(last_len, last_bad));
                launched.push_back(k);
                n = (len_cfg >= 0) ? len_cfg : $urandom_range(1, 24);
                bp = 0;
                if (k != good_key) begin
                    if (n == 0) n = 1;
                    bp = (bpos_cfg > 0 && bpos_cfg <= n) ? bpos_cfg
                                                        : $urandom_range(1, n);
                end
                @(posedge clk); #1;
                a4_rdy = 0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                for (int i = 0; i <= n; i++) begin
                    if (i == 0) b = 8'(n);
                    else if (i == bp) begin
                        if (bbyte_cfg >= 0) b = 8'(bbyte_cfg);
                        else if ($urandom_range(0, 1) == 0)
                            b = 8'($urandom_range(0, 31));
                        else b = 8'($urandom_range(127, 255));
                    end
                    else if (i == 1) b = 8'h20;
                    else if (i == 2) b = 8'h7E;
                    else b = 8'($urandom_range(32, 126));
                    a4_pt_addr = 8'(i);
                    a4_pt_wrdata = b;
                    a4_pt_wren = 1;
                    @(posedge clk); #1;
                end
                a4_pt_wren = 0;
                a4_rdy = 1;
                done_cyc = cyc;
                last_len = n;
                last_bad = bp;
                have_prev = 1;
            end
        end
    end

    task automatic run(input int base, input int good, input int len,
                       input int bpos, input int bbyte, input bit poke);
        int exp_q[$];
        int k, to, m;
        bit exp_found;
        good_key = good;
        len_cfg = len;
        bpos_cfg = bpos;
        bbyte_cfg = bbyte;
        launched.delete();
        have_prev = 0;
        k = base;
        exp_found = 0;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(k);
            if (k == good) begin
                exp_found = 1;
                break;
            end
            k += TSTEP;
            if (k > KMAX) break;
        end
        @(negedge clk);
        chk("rdy_idle", {31'd0, rdy}, 1);
        key_base = KW'(base);
        en = 1;
        @(posedge clk); #1;
        en = 0;
        chk("rdy_drop", {31'd0, rdy}, 0);
        chk("kv_clear", {31'd0, key_valid}, 0);
        chk("a4en_t1", {31'd0, a4_en}, 1);
        if (poke) begin
            to = 0;
            while (a4_rdy && to < 100) begin
                @(negedge clk);
                to++;
            end
            @(negedge clk);
            key_base = KW'(base ^ 'h5a5a5);
            en = 1;
            @(posedge clk); #1;
            en = 0;
        end
        to = 0;
        @(negedge clk);
        while (!rdy && to < 5000) begin
            @(negedge clk);
            to++;
        end
        chk("end_tmo", {31'd0, to < 5000}, 1);
        chk("kv", {31'd0, key_valid}, {31'd0, exp_found});
        if (exp_found) begin
            chk("key", 32'(key), good);
            chk("hit_lat", cyc - done_cyc, hit_lat(last_len));
        end else begin
            chk("exh_lat", cyc - done_cyc, rej_lat(last_len, last_bad));
        end
        chk("n_launch", launched.size(), exp_q.size());
        m = (launched.size() < exp_q.size()) ? launched.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk("lkey", launched[i], exp_q[i]);
    endtask

    task automatic midscan_reset(input int base);
        int to;
        good_key = base;
        len_cfg = 30;
        bpos_cfg = -1;
        bbyte_cfg = -1;
        launched.delete();
        have_prev = 0;
        @(negedge clk);
        key_base = KW'(base);
        en = 1;
        @(posedge clk); #1;
        en = 0;
        to = 0;
        while (a4_rdy && to < 100) begin
            @(negedge clk);
            to++;
        end
        while (!a4_rdy && to < 500) begin
            @(negedge clk);
            to++;
        end
        chk("ms_tmo", {31'd0, to < 500}, 1);
        repeat (5) @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        chk("ms_wren", {31'd0, pt_wren}, 0);
        chk("ms_kv", {31'd0, key_valid}, 0);
        chk("ms_rdy", {31'd0, rdy}, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        chk("ms_rdy_up", {31'd0, rdy}, 1);
        chk("ms_launch", launched.size(), 1);
    endtask

    initial begin
        int b, off;
        rst = 1;
        en = 0;
        key_base = 0;
        good_key = -1;
        len_cfg = 3;
        bpos_cfg = -1;
        bbyte_cfg = -1;
        have_prev = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_ctl", {28'd0, rdy, key_valid, a4_en, pt_wren}, 0);
            chk("rst_key", 32'(key), 0);
            chk("rst_a4key", 32'(a4_key), 0);
            chk("rst_pt", {16'd0, pt_addr, pt_wrdata}, 0);
        end
        @(negedge clk);
        rst = 0;
        chk("rst_rel_rdy", {31'd0, rdy}, 0);
        chk("rst_rel_a4en", {31'd0, a4_en}, 0);
        @(posedge clk); #1;
        chk("rdy_rise", {31'd0, rdy}, 1);

        run('h000000, 'h000000, 3, -1, -1, 0);
        run('h000010, 'h000011, 5, -1, 'h07, 0);
        run('h000100, 'h000101, 8, 1, -1, 0);
        run('h000200, 'h000200, 0, -1, -1, 0);
        run('h000300, 'h000302, 12, 12, 'h7F, 0);
        run('h000400, 'h000401, 6, 3, 'h1F, 0);
        run('hFFFFFE, -1, 6, -1, -1, 0);
        run('hFFFFFF, -1, 4, -1, -1, 0);
        run('h002000, 'h002002, 10, -1, -1, 1);
        midscan_reset('h003000);
        run('h003000, 'h003001, 7, -1, -1, 0);
        for (int i = 0; i < 8; i++) begin
            b = $urandom_range(0, 'hFFF0);
            off = $urandom_range(0, 4);
            run(b, b + off, -1, -1, -1, 0);
        end
        b = KMAX - $urandom_range(0, 2);
        run(b, -1, -1, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
